axi_lite_tpu_bridge: RTL

AXI4-Lite slave that converts host transactions into the TPU's single-beat host port: axi_req, axi_we, axi_addr, axi_wdata in, and axi_rdata out. It sits directly upstream of the tpu top. It is the only master on that port. It also provides channel buffering, read/write arbitration, fixed-latency read capture and error responses.

---
 rtl/axi_lite_tpu_bridge_pkg.sv | 29 ++
 rtl/axi_lite_tpu_bridge_skid_reg.sv | 48 ++++
 rtl/axi_lite_tpu_bridge.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_tpu_bridge_pkg.sv
// ---------------------------------------------------------------------------
// tpu_bridge_pkg
// Shared definitions for the AXI4-Lite to TPU host-port bridge.
//   bridge_state_e : bridge FSM states
//   RESP_OKAY / RESP_SLVERR : AXI response codes
//   ALIGN_MASK     : low address bits that must be zero for a legal 64-bit access
//   is_misaligned  : alignment test on the low address bits
// ---------------------------------------------------------------------------
package tpu_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_ISSUE = 3'd1,
        WR_RESP  = 3'd2,
        RD_ISSUE = 3'd3,
        RD_WAIT  = 3'd4,
        RD_RESP  = 3'd5
    } bridge_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [2:0] ALIGN_MASK  = 3'b111;

    function automatic logic is_misaligned(input logic [2:0] addr_lo);
        return (addr_lo & ALIGN_MASK) != 3'b000;
    endfunction

endpackage

// File: rtl/axi_lite_tpu_bridge_skid_reg.sv
// ---------------------------------------------------------------------------
// skid_reg
// One-entry valid/ready holding register for a single AXI channel.
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   in_valid/in_ready : upstream handshake (ready whenever the entry is empty)
//   in_data           : payload captured on the handshake
//   pop               : consumer releases the entry
//   out_valid/out_data: held entry
// ---------------------------------------------------------------------------
module skid_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         pop,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    logic         vld_q;
    logic [W-1:0] data_q;

    assign in_ready  = !vld_q;
    assign out_valid = vld_q;
    assign out_data  = data_q;

    // Pop and fill can never coincide: pop needs a full entry, fill an empty one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q <= 1'b0;
        end else if (pop) begin
            vld_q <= 1'b0;
        end else if (in_valid && in_ready) begin
            vld_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            data_q <= in_data;
        end
    end

endmodule

// File: rtl/axi_lite_tpu_bridge.sv
// ---------------------------------------------------------------------------
// axi_lite_tpu_bridge
// AXI4-Lite slave that turns host transactions into single-beat requests on
// the TPU host port. One outstanding transaction, responses in issue order.
// Ports:
//   clk, rst                       : clock, asynchronous active-low reset
//   s_aw*, s_w*, s_b*              : AXI4-Lite write address / data / response
//   s_ar*, s_r*                    : AXI4-Lite read address / data
//   axi_req, axi_we, axi_addr,
//   axi_wdata                      : registered one-cycle request to the TPU
//   axi_rdata                      : TPU read data, valid RD_LATENCY cycles
//                                    after the edge that samples axi_req
// ---------------------------------------------------------------------------
module axi_lite_tpu_bridge
    import tpu_bridge_pkg::*;
#(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_awvalid,
    output logic                  s_awready,
    input  logic [ADDR_W-1:0]     s_awaddr,
    input  logic                  s_wvalid,
    output logic                  s_wready,
    input  logic [DATA_W-1:0]     s_wdata,
    input  logic [DATA_W/8-1:0]   s_wstrb,
    output logic                  s_bvalid,
    input  logic                  s_bready,
    output logic [1:0]            s_bresp,
    input  logic                  s_arvalid,
    output logic                  s_arready,
    input  logic [ADDR_W-1:0]     s_araddr,
    output logic                  s_rvalid,
    input  logic                  s_rready,
    output logic [DATA_W-1:0]     s_rdata,
    output logic [1:0]            s_rresp,
    output logic                  axi_req,
    output logic                  axi_we,
    output logic [ADDR_W-1:0]     axi_addr,
    output logic [DATA_W-1:0]     axi_wdata,
    input  logic [DATA_W-1:0]     axi_rdata
);

    localparam int STRB_W = DATA_W / 8;
    localparam int WBUS_W = DATA_W + STRB_W;

    logic                aw_vld;
    logic [ADDR_W-1:0]   aw_addr_q;
    logic                w_vld;
    logic [WBUS_W-1:0]   w_bus_q;
    logic [DATA_W-1:0]   w_data_q;
    logic [STRB_W-1:0]   w_strb_q;
    logic                ar_vld;
    logic [ADDR_W-1:0]   ar_addr_q;

    bridge_state_e       state;
    bridge_state_e       state_next;
    logic                prio_rd;
    logic [2:0]          rd_cnt;

    logic                wr_elig;
    logic                rd_elig;
    logic                wr_err;
    logic                rd_err;
    logic                grant_wr;
    logic                grant_rd;
    logic                rd_capture;

    // Channel holding registers; an entry is released in the cycle it is granted.
    skid_reg #(.W(ADDR_W)) u_aw_q (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s_awvalid),
        .in_ready  (s_awready),
        .in_data   (s_awaddr),
        .pop       (grant_wr),
        .out_valid (aw_vld),
        .out_data  (aw_addr_q)
    );

    skid_reg #(.W(WBUS_W)) u_w_q (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s_wvalid),
        .in_ready  (s_wready),
        .in_data   ({s_wstrb, s_wdata}),
        .pop       (grant_wr),
        .out_valid (w_vld),
        .out_data  (w_bus_q)
    );

    skid_reg #(.W(ADDR_W)) u_ar_q (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s_arvalid),
        .in_ready  (s_arready),
        .in_data   (s_araddr),
        .pop       (grant_rd),
        .out_valid (ar_vld),
        .out_data  (ar_addr_q)
    );

    assign w_data_q   = w_bus_q[DATA_W-1:0];
    assign w_strb_q   = w_bus_q[WBUS_W-1:DATA_W];

    assign wr_elig    = aw_vld && w_vld;
    assign rd_elig    = ar_vld;
    assign wr_err     = is_misaligned(aw_addr_q[2:0]) || !(&w_strb_q);
    assign rd_err     = is_misaligned(ar_addr_q[2:0]);
    assign rd_capture = (state == RD_WAIT) && (rd_cnt == 3'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        grant_wr   = 1'b0;
        grant_rd   = 1'b0;
        case (state)
            IDLE: begin
                if (wr_elig && rd_elig) begin
                    grant_rd = prio_rd;
                    grant_wr = !prio_rd;
                end else begin
                    grant_wr = wr_elig;
                    grant_rd = rd_elig;
                end
                // Faulty requests skip the TPU entirely and go straight to a response.
                if (grant_wr) begin
                    state_next = wr_err ? WR_RESP : WR_ISSUE;
                end else if (grant_rd) begin
                    state_next = rd_err ? RD_RESP : RD_ISSUE;
                end
            end
            WR_ISSUE: state_next = WR_RESP;
            WR_RESP:  if (s_bvalid && s_bready) state_next = IDLE;
            RD_ISSUE: state_next = RD_WAIT;
            RD_WAIT:  if (rd_capture) state_next = RD_RESP;
            RD_RESP:  if (s_rvalid && s_rready) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Registered outputs. The response valids are raised one cycle after an
    // error grant (state already in *_RESP, valid still low), which lines the
    // error responses up with the normal write response timing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            axi_req   <= 1'b0;
            axi_we    <= 1'b0;
            axi_addr  <= '0;
            axi_wdata <= '0;
            s_bvalid  <= 1'b0;
            s_bresp   <= RESP_OKAY;
            s_rvalid  <= 1'b0;
            s_rresp   <= RESP_OKAY;
            s_rdata   <= '0;
            prio_rd   <= 1'b1;
            rd_cnt    <= '0;
        end else begin
            axi_req <= (state_next == WR_ISSUE) || (state_next == RD_ISSUE);

            if (grant_wr && !wr_err) begin
                axi_we    <= 1'b1;
                axi_addr  <= aw_addr_q;
                axi_wdata <= w_data_q;
            end else if (grant_rd && !rd_err) begin
                axi_we    <= 1'b0;
                axi_addr  <= ar_addr_q;
            end

            if ((state == IDLE) && wr_elig && rd_elig) begin
                prio_rd <= !prio_rd;
            end

            if (grant_wr) begin
                s_bresp <= wr_err ? RESP_SLVERR : RESP_OKAY;
            end
            if ((state == WR_RESP) && s_bvalid && s_bready) begin
                s_bvalid <= 1'b0;
            end else if ((state == WR_ISSUE) || ((state == WR_RESP) && !s_bvalid)) begin
                s_bvalid <= 1'b1;
            end

            if (grant_rd) begin
                s_rresp <= rd_err ? RESP_SLVERR : RESP_OKAY;
            end
            if (grant_rd && rd_err) begin
                s_rdata <= '0;
            end else if (rd_capture) begin
                s_rdata <= axi_rdata;
            end
            if ((state == RD_RESP) && s_rvalid && s_rready) begin
                s_rvalid <= 1'b0;
            end else if (rd_capture || ((state == RD_RESP) && !s_rvalid)) begin
                s_rvalid <= 1'b1;
            end

            // Count loads as RD_WAIT is entered; capture happens as it hits zero.
            if (state == RD_ISSUE) begin
                rd_cnt <= 3'(RD_LATENCY);
            end else if (state == RD_WAIT) begin
                rd_cnt <= rd_cnt - 3'd1;
            end
        end
    end

endmodule
